// File: rtl/compressed_prefetch_buffer.sv
// compressed_prefetch_buffer: sequential prefetcher with small FIFO in front of the decompressor
module compressed_prefetch_buffer #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] PCADD = 'b100,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RESETPC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] PCcompress,
  input  logic             Consume,
  output logic             MemReq,
  output logic [WIDTH-1:0] MemAddr,
  input  logic             MemAck,
  input  logic [WIDTH-1:0] MemRdata,
  output logic [WIDTH-1:0] NextInstr,
  output logic             InstrValid
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
  typedef enum logic [1:0] {IDLE, BUSY, DISCARD} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] fifo [DEPTH];
  logic [WIDTH-1:0] expected_pc, fetch_pc;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count, pop_w, push_w;
  logic redirect, pop, push, issue;
  assign redirect = PCcompress != expected_pc;
  assign InstrValid = !redirect && count != '0;
  assign pop = Consume && InstrValid;
  assign pop_w = {{AW{1'b0}}, pop};
  assign push_w = {{AW{1'b0}}, push};
  assign NextInstr = InstrValid ? fifo[rd_ptr] : '0;
  // Fetch FSM: issue when room remains after this cycle's pop; a word acked under redirect is dropped
  always_comb begin
    state_nx = state;
    issue = 1'b0;
    push = 1'b0;
    case (state)
      IDLE: begin
        issue = !redirect && (count - pop_w) < DEPTH_C;
        state_nx = issue ? BUSY : IDLE;
      end
      BUSY: begin
        push = MemAck && !redirect;
        state_nx = MemAck ? IDLE : (redirect ? DISCARD : BUSY);
      end
      DISCARD: state_nx = MemAck ? IDLE : DISCARD;
      default: state_nx = IDLE;
    endcase
  end
  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // Request outputs, PCs and FIFO pointers; a redirect flushes the FIFO and retargets both PCs
  always_ff @(posedge clk) begin
    if (reset) begin
      MemReq <= 1'b0;
      MemAddr <= RESETPC;
      expected_pc <= RESETPC;
      fetch_pc <= RESETPC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (issue) begin
        MemReq <= 1'b1;
        MemAddr <= fetch_pc;
      end else if (state != IDLE && MemAck) begin
        MemReq <= 1'b0;
      end
      if (redirect) begin
        expected_pc <= PCcompress;
        fetch_pc <= PCcompress;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count <= '0;
      end else begin
        if (issue) fetch_pc <= fetch_pc + PCADD;
        if (pop) begin
          expected_pc <= expected_pc + PCADD;
          rd_ptr <= rd_ptr + AW'(1);
        end
        if (push) wr_ptr <= wr_ptr + AW'(1);
        count <= count + push_w - pop_w;
      end
    end
  end
  // FIFO storage, written only on an accepted ack
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= MemRdata;
  end
endmodule

// File: tb/tb_compressed_prefetch_buffer.sv
// tb_compressed_prefetch_buffer: randomized and directed checks against a decompressor/memory reference model
module tb_compressed_prefetch_buffer;
  logic clk = 1'b0;
  logic reset, consume, mem_ack;
  logic [31:0] pc, rdata;
  logic req0, req1, iv0, iv1;
  logic [31:0] addr0, addr1, ni0, ni1;
  bit sel;
  logic mreq, iv;
  logic [31:0] maddr, ni;
  assign mreq = sel ? req1 : req0;
  assign maddr = sel ? addr1 : addr0;
  assign iv = sel ? iv1 : iv0;
  assign ni = sel ? ni1 : ni0;

  compressed_prefetch_buffer #(.RESETPC(32'h0)) dut0 (
    .clk(clk), .reset(reset), .PCcompress(pc), .Consume(consume), .MemReq(req0), .MemAddr(addr0),
    .MemAck(mem_ack), .MemRdata(rdata), .NextInstr(ni0), .InstrValid(iv0));
  compressed_prefetch_buffer #(.RESETPC(32'hFFFFFFF8)) dut1 (
    .clk(clk), .reset(reset), .PCcompress(pc), .Consume(consume), .MemReq(req1), .MemAddr(addr1),
    .MemAck(mem_ack), .MemRdata(rdata), .NextInstr(ni1), .InstrValid(iv1));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, lat = 1, stall = 0, inflight = 0, cnt = 0;
  bit rst, want, force_ack, pend, redir, iv_s, ack_s, newreq_s;
  logic [31:0] cur_pc, pend_addr, last_req, target, rp, ack_addr;
  int ack_cyc;
  logic [31:0] req_q[$];
  int req_c[$];
  logic [31:0] cons_q[$];

  function automatic logic [31:0] mval(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5AC3C3 ^ (a * 32'd2654435761);
  endfunction

  task automatic model_reset();
    pend = 0; redir = 0; last_req = rp - 32'd4; inflight = 0; stall = 0;
    req_q.delete(); req_c.delete(); cons_q.delete();
  endtask

  // one clock: memory responder, decompressor model, output checks, then the edge
  task automatic step(input bit jmp = 0, input logic [31:0] jpc = 0);
    bit ack;
    ack = 0; newreq_s = 0;
    reset = rst;
    if (mem_ack || !mreq) pend = 0;
    if (mreq && !rst) begin
      if (!pend) begin
        pend = 1; cnt = 0; pend_addr = maddr; newreq_s = 1;
        req_q.push_back(maddr); req_c.push_back(cyc);
        checks++;
        if (maddr !== (redir ? target : last_req + 32'd4)) begin
          errors++; $display("FAIL req_addr: got %h expected %h", maddr, redir ? target : last_req + 32'd4);
        end
        redir = 0; last_req = maddr; inflight++;
        checks++;
        if (inflight > 4) begin errors++; $display("FAIL outstanding: got %0d expected <= 4", inflight); end
      end else begin
        checks++;
        if (maddr !== pend_addr) begin errors++; $display("FAIL addr_stable: got %h expected %h", maddr, pend_addr); end
      end
      cnt++;
      ack = cnt >= lat;
    end
    mem_ack = ack || force_ack;
    ack_s = ack;
    if (ack) begin ack_cyc = cyc; ack_addr = pend_addr; end
    rdata = (mem_ack && pend) ? mval(pend_addr) : 32'hDEADBEEF;
    if (jmp) begin cur_pc = jpc; redir = 1; target = jpc; inflight = 0; stall = 0; end
    pc = cur_pc;
    consume = want && !jmp;
    #1;
    iv_s = iv;
    if (!rst) begin
      checks++;
      if (iv ? (ni !== mval(cur_pc)) : (ni !== 32'h0)) begin
        errors++; $display("FAIL next_instr: pc %h valid %b got %h expected %h", cur_pc, iv, ni, iv ? mval(cur_pc) : 32'h0);
      end
      if (jmp) begin
        checks++;
        if (iv !== 1'b0) begin errors++; $display("FAIL redirect_valid: got %b expected 0", iv); end
      end
      stall = (iv === 1'b1) ? 0 : stall + 1;
      checks++;
      if (stall > 30) begin errors++; $display("FAIL valid_timeout: stalled %0d cycles at pc %h", stall, cur_pc); stall = 0; end
      if (want && iv && !jmp) begin cons_q.push_back(ni); cur_pc += 32'd4; inflight--; end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst = 1; force_ack = 0; want = 0; cur_pc = rp;
    repeat (n) step();
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    sel = 0; rp = 32'h0;
    do_reset(2);
    checks += 6;
    if (req0 !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", req0); end
    if (addr0 !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", addr0); end
    if (iv0 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", iv0); end
    if (ni0 !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", ni0); end
    if (req1 !== 1'b0) begin errors++; $display("FAIL reset_req1: got %b expected 0", req1); end
    if (addr1 !== 32'hFFFFFFF8) begin errors++; $display("FAIL reset_addr1: got %h expected fffffff8", addr1); end
  endtask

  task automatic run_stream(input bit s, input logic [31:0] start);
    int first;
    sel = s; rp = start;
    do_reset(1);
    lat = 1; want = 1; first = -1;
    for (int i = 0; i < 40 && cons_q.size() < 4; i++) begin
      step();
      if (iv_s && first < 0) first = i;
    end
    checks++;
    if (first != 2) begin errors++; $display("FAIL first_valid: got %0d expected 2", first); end
    checks++;
    if (cons_q.size() < 4 || req_q.size() < 4) begin
      errors++; $display("FAIL stream_len: got %0d words %0d reqs expected 4", cons_q.size(), req_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks += 2;
        if (req_q[i] !== start + 32'(4 * i)) begin errors++; $display("FAIL stream_addr: got %h expected %h", req_q[i], start + 32'(4 * i)); end
        if (cons_q[i] !== mval(start + 32'(4 * i))) begin errors++; $display("FAIL stream_word: got %h expected %h", cons_q[i], mval(start + 32'(4 * i))); end
      end
      checks++;
      if (req_c[3] - req_c[2] != 2) begin errors++; $display("FAIL throughput: got %0d expected 2", req_c[3] - req_c[2]); end
    end
  endtask

  task automatic test_sequential();
    run_stream(0, 32'h0);
  endtask

  task automatic test_wrap();
    run_stream(1, 32'hFFFFFFF8);
  endtask

  task automatic test_backpressure();
    sel = 0; rp = 32'h0;
    do_reset(1);
    lat = 1; want = 0;
    repeat (20) step();
    checks += 2;
    if (req_q.size() != 4) begin errors++; $display("FAIL bp_reqs: got %0d expected 4", req_q.size()); end
    if (mreq !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b expected 0", mreq); end
    for (int i = 0; i < 4 && i < req_q.size(); i++) begin
      checks++;
      if (req_q[i] !== 32'(4 * i)) begin errors++; $display("FAIL bp_addr: got %h expected %h", req_q[i], 32'(4 * i)); end
    end
    want = 1; step(); want = 0;
    repeat (10) step();
    checks++;
    if (req_q.size() != 5) begin errors++; $display("FAIL bp_one_more: got %0d expected 5", req_q.size()); end
    else begin
      checks++;
      if (req_q[4] !== 32'd16) begin errors++; $display("FAIL bp_addr16: got %h expected 10", req_q[4]); end
    end
  endtask

  // drives until the request for 8 has just appeared, then redirects the following cycle
  task automatic redirect_at8(input int l, input logic [31:0] tgt, output int jc);
    bit found;
    sel = 0; rp = 32'h0;
    do_reset(1);
    lat = l; want = 1; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      found = newreq_s && req_q[$] == 32'd8;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL req8_seen: got 0 expected 1"); end
    jc = cyc;
    step(1, tgt);
  endtask

  task automatic test_redirect_busy();
    int jc, stale_c, nr_c, a_c, v_c;
    redirect_at8(3, 32'h100, jc);
    stale_c = -1; nr_c = -1; a_c = -1; v_c = -1;
    for (int i = 0; i < 40 && v_c < 0; i++) begin
      step();
      if (ack_s && ack_addr == 32'd8) stale_c = ack_cyc;
      if (ack_s && ack_addr == 32'h100) a_c = ack_cyc;
      if (newreq_s && nr_c < 0) begin
        nr_c = cyc - 1;
        checks++;
        if (maddr !== 32'h100) begin errors++; $display("FAIL rb_next_addr: got %h expected 100", maddr); end
      end
      if (iv_s) v_c = cyc - 1;
    end
    checks += 2;
    if (stale_c < 0 || nr_c != stale_c + 2) begin errors++; $display("FAIL rb_discard: stale ack %0d new req %0d expected gap 2", stale_c, nr_c); end
    if (a_c < 0 || v_c != a_c + 1) begin errors++; $display("FAIL rb_valid: got %0d expected %0d", v_c, a_c + 1); end
  endtask

  task automatic test_ack_redirect();
    int jc, a_c, v_c;
    redirect_at8(2, 32'h200, jc);
    checks++;
    if (!(ack_s && ack_addr == 32'd8)) begin errors++; $display("FAIL ar_coincide: got ack %b addr %h expected 1 8", ack_s, ack_addr); end
    step();
    checks++;
    if (iv_s !== 1'b0) begin errors++; $display("FAIL ar_dropped: got valid %b expected 0", iv_s); end
    step();
    checks++;
    if (!(newreq_s && req_q[$] == 32'h200)) begin errors++; $display("FAIL ar_no_stall: got req %b expected 1 at 200", newreq_s); end
    a_c = -1; v_c = -1;
    for (int i = 0; i < 20 && v_c < 0; i++) begin
      step();
      if (ack_s && ack_addr == 32'h200) a_c = ack_cyc;
      if (iv_s) v_c = cyc - 1;
    end
    checks++;
    if (a_c < 0 || v_c != a_c + 1) begin errors++; $display("FAIL ar_valid: got %0d expected %0d", v_c, a_c + 1); end
  endtask

  task automatic test_reset_mid();
    bit found;
    int first;
    sel = 0; rp = 32'h0;
    do_reset(1);
    lat = 3; want = 0; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      found = newreq_s && req_q.size() == 3;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rm_busy2: got %0d reqs expected 3", req_q.size()); end
    rst = 1; force_ack = 1;
    step();
    rst = 0;
    checks += 4;
    if (req0 !== 1'b0) begin errors++; $display("FAIL rm_req: got %b expected 0", req0); end
    if (addr0 !== 32'h0) begin errors++; $display("FAIL rm_addr: got %h expected 0", addr0); end
    if (iv0 !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b expected 0", iv0); end
    if (ni0 !== 32'h0) begin errors++; $display("FAIL rm_instr: got %h expected 0", ni0); end
    model_reset();
    first = -1;
    for (int i = 0; i < 20 && first < 0; i++) begin
      step();
      force_ack = 0;
      if (iv_s) first = i;
    end
    checks += 2;
    if (first != 4) begin errors++; $display("FAIL rm_late_ack: first valid %0d expected 4", first); end
    if (req_q.size() < 1 || req_q[0] !== 32'h0) begin errors++; $display("FAIL rm_refetch: expected first request at 0"); end
  endtask

  task automatic test_random();
    bit j;
    logic [31:0] jpc;
    sel = 0; rp = 32'h0;
    do_reset(1);
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) lat = $urandom_range(1, 4);
      want = ($urandom % 4) != 0;
      j = ($urandom % 24) == 0;
      jpc = ($urandom % 2) ? 32'($urandom_range(0, 255)) << 2 : 32'hFFFFFFE0 + (32'($urandom_range(0, 7)) << 2);
      if (jpc == cur_pc) j = 0;
      step(j, jpc);
    end
  endtask

  initial begin
    reset = 1; pc = 0; consume = 0; mem_ack = 0; rdata = 0; force_ack = 0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_busy();
    test_ack_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
